// File: rtl/seq_addsub_311_pkg.sv
// Shared definitions for the seq_addsub_311 multi-cycle adder/subtractor:
// FSM state encodings and add/subtract mode constants.
package seq_addsub_311_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit_311.sv
// Combinational DIGIT-bit ripple slice of the serial adder/subtractor.
// Subtraction inverts b; the caller supplies cin = 1 on the first digit.
module addsub_digit_311 #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             mode,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;
    logic bx;

    // NOTE: blocking assignments are correct here; c must ripple bit by bit
    // within one evaluation, and every output gets a default so no latch forms.
    always_comb begin
        c        = cin;
        c_msb_in = cin;
        bx       = 1'b0;
        s_d      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            bx     = b_d[i] ^ mode;
            s_d[i] = a_d[i] ^ bx ^ c;
            c      = (a_d[i] & bx) | (a_d[i] & c) | (bx & c);
        end
        cout = c;
    end

endmodule

// File: rtl/seq_addsub_311.sv
// Multi-cycle add/subtract, DIGIT bits per clock, LSB digit first, start/done framed.
// Optional macro ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module seq_addsub_311
    import seq_addsub_311_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic             start_311,
    input  logic             mode_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    output logic             busy_311,
    output logic             done_311,
    output logic [WIDTH-1:0] r_311,
    output logic             cb_311,
    output logic             ovf_311
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, work_q, work_next, s_ext, r_fin;
    logic [DIGIT-1:0] s_d;
    logic [CW-1:0]    cnt_q;
    logic             mode_q, carry_q, a_msb_q;
    logic             cout, c_msb_in, last, cb_fin, ovf_fin;

    addsub_digit_311 #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_sh[DIGIT-1:0]),
        .b_d      (b_sh[DIGIT-1:0]),
        .mode     (mode_q),
        .cin      (carry_q),
        .s_d      (s_d),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    assign last = (cnt_q == CW'(N - 1));

    // New sum digit enters at the top; after N digits the word is aligned.
    assign s_ext     = WIDTH'(s_d) << (WIDTH - DIGIT);
    assign work_next = (work_q >> DIGIT) | s_ext;

    assign cb_fin  = cout ^ mode_q;
    assign ovf_fin = c_msb_in ^ cout;

`ifdef ADDSUB_SAT_EN
    assign r_fin = !ovf_fin ? work_next :
                   a_msb_q  ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign r_fin = work_next;
`endif

    assign busy_311 = (state_q != ST_IDLE);
    assign done_311 = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_311) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: all state here is plain registers, so every one is cleared by the
    // async reset; non-blocking assignments keep the edge update order-free.
    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            a_sh    <= '0;
            b_sh    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ADD;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            r_311   <= '0;
            cb_311  <= 1'b0;
            ovf_311 <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_311) begin
                    a_sh    <= a_311;
                    b_sh    <= b_311;
                    mode_q  <= mode_311;
                    carry_q <= mode_311;
                    a_msb_q <= a_311[WIDTH-1];
                    work_q  <= '0;
                    cnt_q   <= '0;
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    work_q  <= work_next;
                    carry_q <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        r_311   <= r_fin;
                        cb_311  <= cb_fin;
                        ovf_311 <= ovf_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub_311.sv
// Directed bench for seq_addsub_311: bit-serial (DIGIT=1) and 4-bit-digit instances
// driven in parallel, checked against hand-computed results.
module tb_seq_addsub_311;

    localparam int W  = 8;
    localparam int N1 = 8;
    localparam int N4 = 2;

    logic         clk_311 = 1'b0;
    logic         rst_311 = 1'b1;
    logic         start_311 = 1'b0;
    logic         mode_311 = 1'b0;
    logic [W-1:0] a_311 = '0;
    logic [W-1:0] b_311 = '0;

    logic         busy, done, cb, ovf;
    logic [W-1:0] r;
    logic         busy4, done4, cb4, ovf4;
    logic [W-1:0] r4;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] hold_r = '0;

    always #5 clk_311 = ~clk_311;

    seq_addsub_311 #(.WIDTH(W), .DIGIT(1)) dut (
        .clk_311(clk_311), .rst_311(rst_311), .start_311(start_311),
        .mode_311(mode_311), .a_311(a_311), .b_311(b_311),
        .busy_311(busy), .done_311(done), .r_311(r), .cb_311(cb), .ovf_311(ovf)
    );

    seq_addsub_311 #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk_311(clk_311), .rst_311(rst_311), .start_311(start_311),
        .mode_311(mode_311), .a_311(a_311), .b_311(b_311),
        .busy_311(busy4), .done_311(done4), .r_311(r4), .cb_311(cb4), .ovf_311(ovf4)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 8'(busy), 8'h0);
        check({tag, "_done"}, 8'(done), 8'h0);
        check({tag, "_r"},    r,        8'h00);
        check({tag, "_cb"},   8'(cb),   8'h0);
        check({tag, "_ovf"},  8'(ovf),  8'h0);
        check({tag, "_r4"},   r4,       8'h00);
        check({tag, "_busy4"}, 8'(busy4), 8'h0);
    endtask

    // One operation with start accepted at edge 0; glitch_edge > 0 re-pulses
    // start with different operands just before that edge.
    task automatic run_op(input string tag, input logic m, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] er,
                          input logic ecb, input logic eovf, input int glitch_edge);
        int done_edge, pulses, done4_edge, pulses4;
        @(negedge clk_311);
        start_311 = 1'b1; mode_311 = m; a_311 = av; b_311 = bv;
        @(posedge clk_311);
        @(negedge clk_311);
        start_311 = 1'b0; a_311 = ~av; b_311 = 8'h5A;
        check({tag, "_busy"}, 8'(busy), 8'h1);
        done_edge = -1; pulses = 0; done4_edge = -1; pulses4 = 0;
        for (int k = 1; k <= N1 + 3; k++) begin
            if (k == glitch_edge) begin
                start_311 = 1'b1; a_311 = 8'hAA; b_311 = 8'h01; mode_311 = ~m;
            end else begin
                start_311 = 1'b0;
            end
            @(posedge clk_311);
            @(negedge clk_311);
            if (k == 1) check({tag, "_hold_r"}, r, hold_r);
            if (done) begin
                pulses++; done_edge = k;
                check({tag, "_r"},   r,       er);
                check({tag, "_cb"},  8'(cb),  8'(ecb));
                check({tag, "_ovf"}, 8'(ovf), 8'(eovf));
            end
            if (done4) begin
                pulses4++; done4_edge = k;
                check({tag, "_r4"},   r4,       er);
                check({tag, "_cb4"},  8'(cb4),  8'(ecb));
                check({tag, "_ovf4"}, 8'(ovf4), 8'(eovf));
            end
        end
        check({tag, "_pulses"},  8'(pulses),     8'd1);
        check({tag, "_latency"}, 8'(done_edge),  8'(N1));
        check({tag, "_pulses4"}, 8'(pulses4),    8'd1);
        check({tag, "_latency4"}, 8'(done4_edge), 8'(N4));
        check({tag, "_idle"},    8'(busy),       8'h0);
        check({tag, "_r_hold"},  r,              er);
        hold_r = er;
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk_311);
        rst_311 = 1'b0;

        run_op("sub_35_12", 1'b1, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 0);
        run_op("sub_12_35", 1'b1, 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 0);
`ifdef ADDSUB_SAT_EN
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        run_op("add_80_80", 1'b0, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 0);
`else
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
        run_op("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0);
`endif
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        run_op("sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1 ^ 1'b0, 0);
        run_op("busy_start", 1'b1, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 3);

        // Abort mid-RUN with reset at edge 4.
        @(negedge clk_311);
        start_311 = 1'b1; mode_311 = 1'b1; a_311 = 8'h35; b_311 = 8'h12;
        @(posedge clk_311);
        @(negedge clk_311);
        start_311 = 1'b0;
        repeat (4) @(posedge clk_311);
        rst_311 = 1'b1;
        #1;
        check_zero("abort");
        @(negedge clk_311);
        rst_311 = 1'b0;
        repeat (3) @(negedge clk_311);
        check("abort_no_done", 8'(done), 8'h0);
        hold_r = 8'h00;
        run_op("post_reset", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
